// File: rtl/cr_fifo_wrap_pkg.sv
// Shared helpers for the parametrised wrapped FIFO: count-width sizing and even parity.
package cr_fifo_wrap_pkg;

  localparam int PAR_MAX_W = 4096;

  function automatic int cnt_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < (depth + 1)) w = i + 1;
    end
    return w;
  endfunction

  // Callers zero-extend to PAR_MAX_W; zero padding does not change parity.
  function automatic logic calc_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cr_fifo_param_core.sv
// Flop-array FIFO core: pointers, count, full/empty, per-entry parity store and pop-time check.
// Write-to-read latency 1, fall-through head; writes dropped when full, reads ignored when empty.
module cr_fifo_param_core
  import cr_fifo_wrap_pkg::*;
#(
  parameter int DATA_W    = 106,
  parameter int DEPTH     = 16,
  parameter int PARITY_EN = 1,
  parameter int CNT_W     = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_wen,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_inject_perr,
  input  logic              i_ren,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic [CNT_W-1:0]  o_cnt_nxt,
  output logic              o_perr
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0]     r_par;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_par_wr;
  logic [PAR_MAX_W-1:0] w_wpad;
  logic [PAR_MAX_W-1:0] w_rpad;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = i_wen & ~w_full;
  assign w_rd_acc = i_ren & ~w_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
        2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
        default: w_cnt_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (i_clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_acc) r_wptr <= ptr_inc(r_wptr);
        if (w_rd_acc) r_rptr <= ptr_inc(r_rptr);
      end
    end
  end

  // Contents survive clear; only reset wipes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_par <= '0;
    end else if (w_wr_acc && !i_clear) begin
      r_mem[r_wptr] <= i_wdata;
      r_par[r_wptr] <= w_par_wr;
    end
  end

  assign w_wpad   = PAR_MAX_W'(i_wdata);
  assign w_rpad   = PAR_MAX_W'(o_rdata);
  assign w_par_wr = calc_par(w_wpad) ^ i_inject_perr;

  assign o_rdata   = r_mem[r_rptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_perr    = (PARITY_EN != 0) && w_rd_acc && (calc_par(w_rpad) != r_par[r_rptr]);

endmodule

// File: rtl/cr_fifo_wrap_param.sv
// Parametrised wrapped FIFO: level flags, high-water mark, sticky status, BIMC pass-through.
// Latency 1 write-to-read; full drops writes (overflow), empty ignores reads (underflow).
module cr_fifo_wrap_param
  import cr_fifo_wrap_pkg::*;
#(
  parameter int DATA_W     = 106,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 1,
  parameter int AEMPTY_LVL = 1,
  parameter int PARITY_EN  = 1,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inject_perr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [CNT_W-1:0]  used_slots,
  output logic [CNT_W-1:0]  free_slots,
  output logic [CNT_W-1:0]  high_water,
  output logic              overflow,
  output logic              underflow,
  output logic              ro_uncorrectable_ecc_error,
  input  logic              bimc_idat,
  input  logic              bimc_isync,
  input  logic              bimc_rst_n,
  output logic              bimc_odat,
  output logic              bimc_osync
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_free_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_perr;
  logic             w_unused_bimc;
  logic             r_afull;
  logic             r_aempty;
  logic [CNT_W-1:0] r_hw;
  logic             r_ovf;
  logic             r_udf;
  logic             r_ecc;

  cr_fifo_param_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PARITY_EN (PARITY_EN),
    .CNT_W     (CNT_W)
  ) u_core (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (clear),
    .i_wen         (wen),
    .i_wdata       (wdata),
    .i_inject_perr (inject_perr),
    .i_ren         (ren),
    .o_rdata       (rdata),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (w_count),
    .o_cnt_nxt     (w_cnt_nxt),
    .o_perr        (w_perr)
  );

  assign w_free_nxt = DEPTH_C - w_cnt_nxt;

  // Level flags come from the next-state count so they line up with full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_hw     <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_ecc    <= 1'b0;
    end else begin
      r_afull  <= (w_free_nxt <= AFULL_C);
      r_aempty <= (w_cnt_nxt <= AEMPTY_C);
      if (clear) begin
        r_hw  <= '0;
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
        r_ecc <= 1'b0;
      end else begin
        if (w_cnt_nxt > r_hw) r_hw <= w_cnt_nxt;
        r_ovf <= r_ovf | (wen & w_full);
        r_udf <= r_udf | (ren & w_empty);
        r_ecc <= r_ecc | w_perr;
      end
    end
  end

  assign full                       = w_full;
  assign empty                      = w_empty;
  assign afull                      = r_afull;
  assign aempty                     = r_aempty;
  assign used_slots                 = w_count;
  assign free_slots                 = DEPTH_C - w_count;
  assign high_water                 = r_hw;
  assign overflow                   = r_ovf;
  assign underflow                  = r_udf;
  assign ro_uncorrectable_ecc_error = r_ecc;

  // No BIMC-visible memory here; the chain just passes through.
  assign bimc_odat     = bimc_idat;
  assign bimc_osync    = bimc_isync;
  assign w_unused_bimc = bimc_rst_n;

endmodule

// File: tb/tb_cr_fifo_wrap_param.sv
// Directed table-driven bench for cr_fifo_wrap_param (DEPTH 16 main instance, DEPTH 5 wrap instance).
module tb_cr_fifo_wrap_param;

  localparam int DW   = 106;
  localparam int DEP  = 16;
  localparam int CW   = 5;
  localparam int DW5  = 8;
  localparam int DEP5 = 5;
  localparam int CW5  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          clear = 1'b0, wen = 1'b0, ren = 1'b0, inject_perr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          full, empty, afull, aempty, overflow, underflow, ecc_err;
  logic [CW-1:0] used_slots, free_slots, high_water;
  logic          bimc_idat = 1'b0, bimc_isync = 1'b0;
  logic          bimc_odat, bimc_osync;

  logic           wen5 = 1'b0, ren5 = 1'b0;
  logic [DW5-1:0] wdata5 = '0;
  logic [DW5-1:0] rdata5;
  logic           full5, empty5, afull5, aempty5, ovf5, udf5, ecc5;
  logic [CW5-1:0] used5, free5, hw5;
  logic           bimc_odat5, bimc_osync5;

  int  n_run  = 0;
  int  n_fail = 0;
  logic done  = 1'b0;

  cr_fifo_wrap_param #(
    .DATA_W(DW), .DEPTH(DEP), .AFULL_LVL(1), .AEMPTY_LVL(1), .PARITY_EN(1), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wen(wen), .wdata(wdata),
    .inject_perr(inject_perr), .ren(ren), .rdata(rdata), .full(full), .empty(empty),
    .afull(afull), .aempty(aempty), .used_slots(used_slots), .free_slots(free_slots),
    .high_water(high_water), .overflow(overflow), .underflow(underflow),
    .ro_uncorrectable_ecc_error(ecc_err), .bimc_idat(bimc_idat), .bimc_isync(bimc_isync),
    .bimc_rst_n(rst_n), .bimc_odat(bimc_odat), .bimc_osync(bimc_osync)
  );

  cr_fifo_wrap_param #(
    .DATA_W(DW5), .DEPTH(DEP5), .AFULL_LVL(2), .AEMPTY_LVL(0), .PARITY_EN(0), .CNT_W(CW5)
  ) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .wen(wen5), .wdata(wdata5),
    .inject_perr(1'b0), .ren(ren5), .rdata(rdata5), .full(full5), .empty(empty5),
    .afull(afull5), .aempty(aempty5), .used_slots(used5), .free_slots(free5),
    .high_water(hw5), .overflow(ovf5), .underflow(udf5),
    .ro_uncorrectable_ecc_error(ecc5), .bimc_idat(bimc_isync), .bimc_isync(bimc_idat),
    .bimc_rst_n(rst_n), .bimc_odat(bimc_odat5), .bimc_osync(bimc_osync5)
  );

  typedef struct {
    logic          clr, wen, ren, inj;
    logic [DW-1:0] wd;
    logic [CW-1:0] used, hw;
    logic [6:0]    flags;   // full empty afull aempty ovf udf ecc
    logic          rd_chk;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] W(input int k);
    return {16'hBEEF, 58'h0, 32'(k)};
  endfunction

  function automatic logic [DW5-1:0] W5(input int k);
    return DW5'(8'h40 + 7 * k);
  endfunction

  function automatic logic [6:0] F(input logic f, e, af, ae, ov, ud, ec);
    return {f, e, af, ae, ov, ud, ec};
  endfunction

  task automatic addv(input logic c, w, r, inj, input logic [DW-1:0] wd, input int used, hw,
                      input logic [6:0] fl, input logic rdc, input logic [DW-1:0] rd);
    vec_t v;
    v.clr = c; v.wen = w; v.ren = r; v.inj = inj; v.wd = wd;
    v.used = CW'(used); v.hw = CW'(hw); v.flags = fl; v.rd_chk = rdc; v.rd = rd;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // BIMC chain must follow its inputs at all times, including during reset.
  initial begin
    while (!done) begin
      bimc_idat  = 1'($urandom_range(0, 1));
      bimc_isync = 1'($urandom_range(0, 1));
      #1;
      chk("bimc", 128'({bimc_odat, bimc_osync, bimc_odat5, bimc_osync5}),
          128'({bimc_idat, bimc_isync, bimc_isync, bimc_idat}));
      #6;
    end
  end

  initial begin
    // 14/15/16 writes: afull with free=1, full with free=0
    for (int k = 1; k <= 16; k++)
      addv(0, 1, 0, 0, W(k), k, k, F(k == 16, 0, k >= 15, k <= 1, 0, 0, 0), 1, W(1));
    // full with wen&ren: pop accepted, write rejected
    addv(0, 1, 1, 0, W(99), 15, 16, F(0, 0, 1, 0, 1, 0, 0), 1, W(2));
    for (int j = 1; j <= 15; j++)
      addv(0, 0, 1, 0, '0, 15 - j, 16, F(0, j == 15, 0, j >= 14, 1, 0, 0), j < 15, W(2 + j));
    addv(0, 0, 1, 0, '0, 0, 16, F(0, 1, 0, 1, 1, 1, 0), 0, '0);
    addv(1, 0, 0, 0, '0, 0, 0, F(0, 1, 0, 1, 0, 0, 0), 0, '0);
    addv(1, 1, 0, 0, W(50), 0, 0, F(0, 1, 0, 1, 0, 0, 0), 0, '0);
    // parity: clean 0x5, then 0x3 with injected error
    addv(0, 1, 0, 0, DW'(5), 1, 1, F(0, 0, 0, 1, 0, 0, 0), 1, DW'(5));
    addv(0, 1, 0, 1, DW'(3), 2, 2, F(0, 0, 0, 0, 0, 0, 0), 1, DW'(5));
    addv(0, 0, 1, 0, '0, 1, 2, F(0, 0, 0, 1, 0, 0, 0), 1, DW'(3));
    addv(0, 0, 1, 0, '0, 0, 2, F(0, 1, 0, 1, 0, 0, 1), 0, '0);
    addv(0, 0, 0, 0, '0, 0, 2, F(0, 1, 0, 1, 0, 0, 1), 0, '0);
    addv(1, 0, 0, 0, '0, 0, 0, F(0, 1, 0, 1, 0, 0, 0), 0, '0);
    // high-water: 10 in, 10 out, 3 in
    for (int k = 1; k <= 10; k++)
      addv(0, 1, 0, 0, W(200 + k), k, k, F(0, 0, 0, k <= 1, 0, 0, 0), 1, W(201));
    for (int j = 1; j <= 10; j++)
      addv(0, 0, 1, 0, '0, 10 - j, 10, F(0, j == 10, 0, (10 - j) <= 1, 0, 0, 0), j < 10, W(201 + j));
    for (int k = 1; k <= 3; k++)
      addv(0, 1, 0, 0, W(300 + k), k, 10, F(0, 0, 0, k <= 1, 0, 0, 0), 1, W(301));
    // empty with wen&ren: write accepted, read rejected
    addv(1, 0, 0, 0, '0, 0, 0, F(0, 1, 0, 1, 0, 0, 0), 0, '0);
    addv(0, 1, 1, 0, W(400), 1, 1, F(0, 0, 0, 1, 0, 1, 0), 1, W(400));
    addv(0, 1, 1, 0, W(401), 1, 1, F(0, 0, 0, 1, 0, 1, 0), 1, W(401));

    #12;
    chk("rst flags", 128'({full, empty, afull, aempty, overflow, underflow, ecc_err}),
        128'(F(0, 1, 0, 1, 0, 0, 0)));
    chk("rst used", 128'(used_slots), 128'(0));
    chk("rst free", 128'(free_slots), 128'(DEP));
    chk("rst hw", 128'(high_water), 128'(0));
    chk("rst rdata", 128'(rdata), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      clear = tbl[i].clr; wen = tbl[i].wen; ren = tbl[i].ren;
      inject_perr = tbl[i].inj; wdata = tbl[i].wd;
      step();
      chk($sformatf("v%0d used", i), 128'(used_slots), 128'(tbl[i].used));
      chk($sformatf("v%0d free", i), 128'(free_slots), 128'(DEP - int'(tbl[i].used)));
      chk($sformatf("v%0d flags", i),
          128'({full, empty, afull, aempty, overflow, underflow, ecc_err}), 128'(tbl[i].flags));
      chk($sformatf("v%0d hw", i), 128'(high_water), 128'(tbl[i].hw));
      if (tbl[i].rd_chk) chk($sformatf("v%0d rdata", i), 128'(rdata), 128'(tbl[i].rd));
    end
    clear = 1'b0; wen = 1'b0; ren = 1'b0; inject_perr = 1'b0;

    // Async reset mid-burst with 7 entries held
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      wen = 1'b1; wdata = W(500 + k);
      step();
    end
    wen = 1'b0;
    chk("burst used", 128'(used_slots), 128'(7));
    #3 rst_n = 1'b0;
    #1;
    chk("arst flags", 128'({full, empty, afull, aempty, overflow, underflow, ecc_err}),
        128'(F(0, 1, 0, 1, 0, 0, 0)));
    chk("arst used", 128'(used_slots), 128'(0));
    chk("arst hw", 128'(high_water), 128'(0));
    chk("arst rdata", 128'(rdata), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // DEPTH=5 streaming: 12 transactions wrap both pointers twice
    begin
      int rd_i;
      rd_i = 1;
      for (int c = 0; c < 15; c++) begin
        wen5   = (c < 12);
        wdata5 = W5(c + 1);
        ren5   = (c >= 3);
        if (ren5) begin
          chk($sformatf("wrap rd%0d", rd_i), 128'(rdata5), 128'(W5(rd_i)));
          rd_i++;
        end
        step();
        if (c == 2 || c == 11) begin
          chk($sformatf("wrap used c%0d", c), 128'(used5), 128'(3));
          chk($sformatf("wrap lvl c%0d", c), 128'({afull5, aempty5}), 128'(2'b10));
        end
      end
      wen5 = 1'b0; ren5 = 1'b0;
      chk("wrap end", 128'({used5, empty5, aempty5, full5, ovf5, udf5, ecc5, hw5}),
          128'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3}));
    end

    done = 1'b1;
    #10;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
